// File: rtl/onehot_scan_decoder_pkg.sv
// Shared types for the decoder family: FSM state encodings and small helpers.
package onehot_scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } dec_state_e;

  function automatic logic is_live(input dec_state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-channel dwell counter for scan mode; tick is asserted in the cycle where cnt >= dwell.
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] cnt;

  // >= rather than == so that lowering dwell mid-count advances on the next edge
  assign tick = enable && (cnt >= dwell);

  always_ff @(posedge clk) begin
    if (rst || clear)  cnt <= '0;
    else if (enable)   cnt <= tick ? '0 : cnt + ONE;
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered N-to-NUM_OUT one-hot decoder with hold and auto-scan modes.
// Optional DEC_BIDIR_SCAN_EN adds a dir input (1 = scan downwards).
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
`ifdef DEC_BIDIR_SCAN_EN
  input  logic               dir,
`endif
  input  logic               load_stb,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] y,
  output logic [SEL_W-1:0]   idx,
  output logic               valid,
  output logic               wrap,
  output logic               sel_err
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  dec_state_e         st, st_n;
  logic [SEL_W-1:0]   idx_n;
  logic [NUM_OUT-1:0] y_n;
  logic               wrap_n, err_n, legal, tmr_clr, tmr_en, tick;

  // one extra bit so NUM_OUT == 2**SEL_W still compares correctly
  assign legal = ({1'b0, sel} < (SEL_W+1)'(NUM_OUT));

  dwell_timer #(.DWELL_W(DWELL_W)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .dwell  (dwell),
    .tick   (tick)
  );

  always_comb begin
    st_n    = st;
    idx_n   = idx;
    wrap_n  = 1'b0;
    err_n   = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    if (!en) begin
      st_n    = ST_IDLE;
      tmr_clr = 1'b1;
    end else if (load_stb) begin
      if (legal) begin
        idx_n   = sel;
        tmr_clr = 1'b1;
        st_n    = mode ? ST_SCAN : ST_HOLD;
      end else begin
        err_n = 1'b1;
      end
    end else begin
      unique case (st)
        ST_IDLE, ST_HOLD: begin
          if (mode) begin
            st_n    = ST_SCAN;
            tmr_clr = 1'b1;
          end
        end
        ST_SCAN: begin
          if (!mode) begin
            st_n    = ST_HOLD;
            tmr_clr = 1'b1;
          end else begin
            tmr_en = 1'b1;
            if (tick) begin
`ifdef DEC_BIDIR_SCAN_EN
              if (dir) begin
                wrap_n = (idx == '0);
                idx_n  = (idx == '0) ? LAST : idx - ONE;
              end else
`endif
              begin
                wrap_n = (idx == LAST);
                idx_n  = (idx == LAST) ? '0 : idx + ONE;
              end
            end
          end
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_dec
    assign y_n[i] = is_live(st_n) && (idx_n == SEL_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      idx     <= '0;
      y       <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      st      <= st_n;
      idx     <= idx_n;
      y       <= y_n;
      valid   <= is_live(st_n);
      wrap    <= wrap_n;
      sel_err <= err_n;
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: NUM_OUT=8 main instance plus a NUM_OUT=6 instance for range rejection.
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, en, mode, load_stb;
  logic [2:0] sel;
  logic [3:0] dwell;
`ifdef DEC_BIDIR_SCAN_EN
  logic       dir = 1'b0;
`endif

  logic [7:0] y;
  logic [2:0] idx;
  logic       valid, wrap, sel_err;
  logic [5:0] y6;
  logic [2:0] idx6;
  logic       valid6, wrap6, sel_err6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef DEC_BIDIR_SCAN_EN
    .dir(dir),
`endif
    .load_stb(load_stb), .sel(sel), .dwell(dwell),
    .y(y), .idx(idx), .valid(valid), .wrap(wrap), .sel_err(sel_err)
  );

  onehot_scan_decoder #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(4)) u_dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef DEC_BIDIR_SCAN_EN
    .dir(dir),
`endif
    .load_stb(load_stb), .sel(sel), .dwell(dwell),
    .y(y6), .idx(idx6), .valid(valid6), .wrap(wrap6), .sel_err(sel_err6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge, sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_idx [10];
    exp_idx = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1};

    rst = 1'b1; en = 1'b0; mode = 1'b0; load_stb = 1'b0; sel = '0; dwell = '0;
    step(); step();
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_idx", 32'(idx), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_err", 32'(sel_err), 32'h0);

    // first load from IDLE into HOLD
    rst = 1'b0; en = 1'b1; mode = 1'b0; load_stb = 1'b1; sel = 3'd5;
    step();
    chk("load5_y", 32'(y), 32'h20);
    chk("load5_valid", 32'(valid), 32'h1);
    chk("load5_idx", 32'(idx), 32'h5);

    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step();
      chk($sformatf("hold_y%0d", s), 32'(y), 32'h1 << s);
      chk($sformatf("hold_err%0d", s), 32'(sel_err), 32'h0);
    end

    // HOLD freezes output without a strobe
    load_stb = 1'b0; sel = 3'd2;
    step();
    chk("hold_frozen", 32'(y), 32'h80);

    // range rejection on the 6-output instance
    load_stb = 1'b1; sel = 3'd2;
    step();
    chk("n6_load2", 32'(y6), 32'h04);
    sel = 3'd6;
    step();
    chk("n6_err", 32'(sel_err6), 32'h1);
    chk("n6_y_kept", 32'(y6), 32'h04);
    chk("n6_idx_kept", 32'(idx6), 32'h2);
    chk("n8_sel6", 32'(y), 32'h40);
    load_stb = 1'b0;
    step();
    chk("n6_err_pulse", 32'(sel_err6), 32'h0);

    // scan with dwell=2 starting at 6
    mode = 1'b1; dwell = 4'd2; load_stb = 1'b1; sel = 3'd6;
    step();
    load_stb = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      chk($sformatf("scan_idx%0d", k), 32'(idx), 32'(exp_idx[k]));
      chk($sformatf("scan_wrap%0d", k), 32'(wrap), (k == 6) ? 32'h1 : 32'h0);
    end
    chk("scan_y", 32'(y), 32'h02);

    // dwell=0 with a reload mid-scan
    dwell = 4'd0; load_stb = 1'b1; sel = 3'd5;
    step();
    chk("d0_idx5", 32'(idx), 32'h5);
    sel = 3'd3;
    step();
    chk("d0_reload3", 32'(idx), 32'h3);
    load_stb = 1'b0;
    step();
    chk("d0_adv4", 32'(idx), 32'h4);
    en = 1'b0;
    step();
    chk("dis_y", 32'(y), 32'h0);
    chk("dis_valid", 32'(valid), 32'h0);
    chk("dis_idx", 32'(idx), 32'h4);

    // reset mid-scan at the wrap point
    en = 1'b1; load_stb = 1'b1; sel = 3'd7;
    step();
    chk("pre_rst_y", 32'(y), 32'h80);
    load_stb = 1'b0; rst = 1'b1;
    step();
    chk("mrst_y", 32'(y), 32'h0);
    chk("mrst_idx", 32'(idx), 32'h0);
    chk("mrst_valid", 32'(valid), 32'h0);
    chk("mrst_wrap", 32'(wrap), 32'h0);

    // lowering dwell below the running count advances on the next edge
    rst = 1'b0; dwell = 4'd5; load_stb = 1'b1; sel = 3'd0;
    step();
    load_stb = 1'b0;
    step(); step();
    chk("dlow_before", 32'(idx), 32'h0);
    dwell = 4'd1;
    step();
    chk("dlow_adv", 32'(idx), 32'h1);

    // IDLE with mode=1 and no strobe resumes scanning from retained idx
    en = 1'b0;
    step();
    chk("resume_idle", 32'(valid), 32'h0);
    en = 1'b1;
    step();
    chk("resume_valid", 32'(valid), 32'h1);
    chk("resume_y", 32'(y), 32'h02);

`ifdef DEC_BIDIR_SCAN_EN
    dwell = 4'd0; dir = 1'b1; load_stb = 1'b1; sel = 3'd1;
    step();
    load_stb = 1'b0;
    chk("dn_idx1", 32'(idx), 32'h1);
    step();
    chk("dn_idx0", 32'(idx), 32'h0);
    step();
    chk("dn_idx7", 32'(idx), 32'h7);
    chk("dn_wrap", 32'(wrap), 32'h1);
    step();
    chk("dn_idx6", 32'(idx), 32'h6);
    chk("dn_wrap_off", 32'(wrap), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
